// File: rtl/leddc_pkg.sv
// -----------------------------------------------------------------------------
// leddc_pkg
// Shared definitions for the LEDDC frame source:
//   - default geometry (pixel width, channels per row, rows per frame, gaps)
//   - FSM state encodings (IDLE, LOAD, SHIFT, GAP, VSYNC)
//   - cnt_w(): counter width helper used to size every counter
// No ports (package).
// -----------------------------------------------------------------------------
package leddc_pkg;

    // Default frame geometry
    localparam int PIX_W_D   = 16;
    localparam int CH_NUM_D  = 16;
    localparam int ROWS_D    = 16;
    localparam int GAP_CYC_D = 4;
    localparam int VS_LEN_D  = 2;

    // Width of a counter that holds 0..n-1 (never narrower than one bit)
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Counter widths for the default geometry
    localparam int BIT_CNT_W = cnt_w(PIX_W_D);
    localparam int CH_CNT_W  = cnt_w(CH_NUM_D);
    localparam int ROW_CNT_W = cnt_w(ROWS_D);
    localparam int TMR_CNT_W = cnt_w((GAP_CYC_D > VS_LEN_D) ? GAP_CYC_D : VS_LEN_D);

    // FSM state encodings
    typedef logic [2:0] leddc_state_t;
    localparam leddc_state_t ST_IDLE  = 3'd0;
    localparam leddc_state_t ST_LOAD  = 3'd1;
    localparam leddc_state_t ST_SHIFT = 3'd2;
    localparam leddc_state_t ST_GAP   = 3'd3;
    localparam leddc_state_t ST_VSYNC = 3'd4;

endpackage

// File: rtl/leddc_tx_ser.sv
// -----------------------------------------------------------------------------
// leddc_tx_ser
// PIX_W-bit MSB-first serializer with bit counter.
// Ports:
//   DCK        in   clock, all state updates on posedge
//   rst_n      in   synchronous active-low reset
//   load       in   capture din, bit counter to PIX_W-1
//   shift      in   shift left one bit, bit counter down by one
//   din        in   parallel word
//   msb        out  current serial bit (register output)
//   last       out  bit counter is 0: current bit is the word's LSB
//   next_last  out  bit counter is 1: the next cycle carries the LSB
// -----------------------------------------------------------------------------
module leddc_tx_ser
    import leddc_pkg::*;
#(
    parameter int PIX_W = PIX_W_D
) (
    input  logic             DCK,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [PIX_W-1:0] din,
    output logic             msb,
    output logic             last,
    output logic             next_last
);

    localparam int            BW       = cnt_w(PIX_W);
    localparam logic [BW-1:0] BIT_TOP  = BW'(PIX_W - 1);
    localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] BIT_ONE  = BW'(1'b1);

    logic [PIX_W-1:0] sh_r;
    logic [BW-1:0]    bit_r;

    // Shift register and bit counter; load wins over shift so a new word can
    // follow the last bit of the previous one without a hole. Shifting in
    // zeros leaves the register clear once a word has fully drained, which
    // keeps msb at 0 outside of SHIFT.
    always_ff @(posedge DCK) begin
        if (!rst_n) begin
            sh_r  <= {PIX_W{1'b0}};
            bit_r <= BIT_ZERO;
        end else if (load) begin
            sh_r  <= din;
            bit_r <= BIT_TOP;
        end else if (shift) begin
            sh_r  <= {sh_r[PIX_W-2:0], 1'b0};
            bit_r <= (bit_r == BIT_ZERO) ? BIT_ZERO : (bit_r - BIT_ONE);
        end else begin
            sh_r  <= sh_r;
            bit_r <= bit_r;
        end
    end

    assign msb       = sh_r[PIX_W-1];
    assign last      = (bit_r == BIT_ZERO);
    assign next_last = (bit_r == BIT_ONE);

endmodule

// File: rtl/leddc_tx.sv
// -----------------------------------------------------------------------------
// leddc_tx
// Frame source for the LED display controller. Pulls PIX_W-bit gray values
// through a valid/ready handshake, serializes them MSB first on DAI with DEN
// marking every valid bit, idles GAP_CYC cycles between row bursts and ends
// each frame with a VS_LEN-cycle Vsync strobe followed by a one-cycle done.
// All outputs are registers.
//
// Optional build macro: LEDDC_TX_PATTERN_EN
//   adds input pat_sel (sampled with start). When set, each word is the
//   internal pattern {row_cnt, ch_cnt} zero-extended to PIX_W, pix_ready
//   stays 0 and LOAD never stalls.
//
// Ports:
//   DCK        in   clock
//   rst_n      in   synchronous active-low reset (aborts a frame)
//   start      in   one-cycle frame request, ignored unless idle
//   mode       in   frame depth select, sampled with start
//   pat_sel    in   pattern select (LEDDC_TX_PATTERN_EN builds only)
//   pix_data   in   pixel value
//   pix_valid  in   pix_data valid
//   pix_ready  out  accept; transfer on pix_valid && pix_ready
//   DAI        out  serial data, MSB first
//   DEN        out  high on cycles carrying a DAI bit
//   Vsync      out  frame-end strobe
//   MODE_O     out  mode latched at start
//   busy       out  frame in progress
//   done       out  one-cycle pulse when the frame finishes
// -----------------------------------------------------------------------------
module leddc_tx
    import leddc_pkg::*;
#(
    parameter int PIX_W   = PIX_W_D,
    parameter int CH_NUM  = CH_NUM_D,
    parameter int ROWS    = ROWS_D,
    parameter int GAP_CYC = GAP_CYC_D,
    parameter int VS_LEN  = VS_LEN_D
) (
    input  logic             DCK,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
`ifdef LEDDC_TX_PATTERN_EN
    input  logic             pat_sel,
`endif
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             DAI,
    output logic             DEN,
    output logic             Vsync,
    output logic             MODE_O,
    output logic             busy,
    output logic             done
);

    localparam int CW      = cnt_w(CH_NUM);
    localparam int RW      = cnt_w(ROWS);
    localparam int TMR_MAX = (GAP_CYC > VS_LEN) ? GAP_CYC : VS_LEN;
    localparam int TW      = cnt_w(TMR_MAX);

    localparam logic [CW-1:0] CH_LAST  = CW'(CH_NUM - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] VS_LAST  = TW'(VS_LEN - 1);

    // Registers
    leddc_state_t  state_r;
    logic [CW-1:0] ch_r;
    logic [RW-1:0] row_r;
    logic [TW-1:0] tmr_r;
    logic          slot_r;     // a word may be taken this cycle
    logic          ready_r;
    logic          den_r;
    logic          vsync_r;
    logic          mode_r;
    logic          busy_r;
    logic          done_r;

    // Next-state / control signals
    leddc_state_t     state_s;
    logic [CW-1:0]    ch_s;
    logic [RW-1:0]    row_s;
    logic [TW-1:0]    tmr_s;
    logic             slot_s;
    logic             take_s;
    logic             load_s;
    logic             shift_s;
    logic             start_ok_s;
    logic             pat_s;
    logic             pat_nxt_s;
    logic [PIX_W-1:0] din_s;
    logic             ser_msb_s;
    logic             ser_last_s;
    logic             ser_next_last_s;

    // The done cycle is already IDLE, so start is masked there explicitly.
    assign start_ok_s = (state_r == ST_IDLE) && start && !done_r;

`ifdef LEDDC_TX_PATTERN_EN
    logic             pat_r;
    logic [PIX_W-1:0] pat_word_s;

    // Pattern select, latched together with mode at frame start
    always_ff @(posedge DCK) begin
        if (!rst_n) begin
            pat_r <= 1'b0;
        end else if (start_ok_s) begin
            pat_r <= pat_sel;
        end else begin
            pat_r <= pat_r;
        end
    end

    // Pattern word {row, channel}; ch_s is the index of the word being loaded
    // both in LOAD and on a back-to-back take at the last bit of SHIFT.
    always_comb begin
        pat_word_s                = {PIX_W{1'b0}};
        pat_word_s[CW+RW-1:0]     = {row_r, ch_s};
    end

    assign pat_s     = pat_r;
    assign pat_nxt_s = start_ok_s ? pat_sel : pat_r;
    assign din_s     = pat_r ? pat_word_s : pix_data;
`else
    assign pat_s     = 1'b0;
    assign pat_nxt_s = 1'b0;
    assign din_s     = pix_data;
`endif

    // In pattern mode every offered slot is taken without a handshake.
    assign take_s = slot_r && (pat_s || pix_valid);

    // Frame sequencing: next state, counters and serializer control
    always_comb begin
        state_s = state_r;
        ch_s    = ch_r;
        row_s   = row_r;
        tmr_s   = tmr_r;
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (take_s) begin
                    load_s  = 1'b1;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                if (ser_last_s) begin
                    if (ch_r == CH_LAST) begin
                        ch_s  = {CW{1'b0}};
                        tmr_s = {TW{1'b0}};
                        if (row_r == ROW_LAST) begin
                            state_s = ST_VSYNC;
                        end else begin
                            state_s = ST_GAP;
                        end
                    end else begin
                        ch_s = ch_r + CW'(1'b1);
                        if (take_s) begin
                            load_s = 1'b1;
                        end else begin
                            state_s = ST_LOAD;
                        end
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (tmr_r == GAP_LAST) begin
                    tmr_s   = {TW{1'b0}};
                    row_s   = row_r + RW'(1'b1);
                    state_s = ST_LOAD;
                end else begin
                    tmr_s = tmr_r + TW'(1'b1);
                end
            end
            ST_VSYNC: begin
                if (tmr_r == VS_LAST) begin
                    tmr_s   = {TW{1'b0}};
                    row_s   = {RW{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    tmr_s = tmr_r + TW'(1'b1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                ch_s    = {CW{1'b0}};
                row_s   = {RW{1'b0}};
                tmr_s   = {TW{1'b0}};
            end
        endcase
    end

    // A take slot is offered in LOAD and on the last bit of a word that still
    // has a successor in the same row (next_last marks the cycle before it).
    always_comb begin
        slot_s = 1'b0;
        if (state_s == ST_LOAD) begin
            slot_s = 1'b1;
        end else if ((state_r == ST_SHIFT) && ser_next_last_s && (ch_r != CH_LAST)) begin
            slot_s = 1'b1;
        end else begin
            slot_s = 1'b0;
        end
    end

    // FSM, counters and registered outputs
    always_ff @(posedge DCK) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ch_r    <= {CW{1'b0}};
            row_r   <= {RW{1'b0}};
            tmr_r   <= {TW{1'b0}};
            slot_r  <= 1'b0;
            ready_r <= 1'b0;
            den_r   <= 1'b0;
            vsync_r <= 1'b0;
            mode_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ch_r    <= ch_s;
            row_r   <= row_s;
            tmr_r   <= tmr_s;
            slot_r  <= slot_s;
            ready_r <= slot_s && !pat_nxt_s;
            den_r   <= (state_s == ST_SHIFT);
            vsync_r <= (state_s == ST_VSYNC);
            mode_r  <= start_ok_s ? mode : mode_r;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_r == ST_VSYNC) && (state_s == ST_IDLE);
        end
    end

    leddc_tx_ser #(
        .PIX_W (PIX_W)
    ) u_ser (
        .DCK       (DCK),
        .rst_n     (rst_n),
        .load      (load_s),
        .shift     (shift_s),
        .din       (din_s),
        .msb       (ser_msb_s),
        .last      (ser_last_s),
        .next_last (ser_next_last_s)
    );

    assign pix_ready = ready_r;
    assign DAI       = ser_msb_s;
    assign DEN       = den_r;
    assign Vsync     = vsync_r;
    assign MODE_O    = mode_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_leddc_tx.sv
// -----------------------------------------------------------------------------
// tb_leddc_tx
// Self-checking bench for leddc_tx (default geometry 16x16x16, GAP 4, VS 2).
// A table of words with hand-written MSB-first bit strings opens the first
// frame; the rest of each frame is checked against a queue of accepted words.
// Hand-written sequences cover stalls, mode/start during a frame, start in
// VSYNC/done, reset abort and (with LEDDC_TX_PATTERN_EN) the pattern source.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_leddc_tx;

    localparam int NV       = 7;
    localparam int GAP_CYC  = 4;
    localparam int WORDS    = 256;
    localparam int ROW_RUNS = 15;

    typedef struct {
        logic [15:0] pix;
        logic [15:0] bits;
    } vec_t;

    logic        DCK = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        DAI;
    logic        DEN;
    logic        Vsync;
    logic        MODE_O;
    logic        busy;
    logic        done;
`ifdef LEDDC_TX_PATTERN_EN
    logic        pat_sel;
`endif

    always #5 DCK = ~DCK;

    leddc_tx dut (
        .DCK       (DCK),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
`ifdef LEDDC_TX_PATTERN_EN
        .pat_sel   (pat_sel),
`endif
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .DAI       (DAI),
        .DEN       (DEN),
        .Vsync     (Vsync),
        .MODE_O    (MODE_O),
        .busy      (busy),
        .done      (done)
    );

    int          total = 0;
    int          bad   = 0;
    vec_t        vec[NV];
    logic [15:0] exp_q[$];
    logic [15:0] word_acc;
    logic        exp_mode;
    bit          pat_mode = 1'b0;
    bit          use_tab  = 1'b0;
    int cyc_n = 0, src_i, nb, rxi, den_hi, acc_n, vs_cnt, vs_bad, done_cnt, mode_bad;
    int ready_hi, run_len, runs_gap, runs_other, other_len, first_acc, first_den;
    int stall_at = -1, stall_left = 0;
    bit seen_den;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    function automatic logic [15:0] src_word(input int i);
        if (use_tab && i < NV) return vec[i].pix;
        else return 16'((i * 40503) ^ 23130);
    endfunction

    task automatic clear_stats();
        exp_q.delete();
        nb = 0; rxi = 0; den_hi = 0; acc_n = 0; vs_cnt = 0; vs_bad = 0; done_cnt = 0;
        mode_bad = 0; ready_hi = 0; run_len = 0; runs_gap = 0; runs_other = 0;
        other_len = 0; first_acc = -1; first_den = -1; seen_den = 1'b0; word_acc = 16'h0000;
    endtask

    task automatic check_word();
        logic [15:0] w;
        if (pat_mode) begin
            w = 16'(rxi);
        end else if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL word_%0d: got %h, expected no word", rxi, word_acc);
            return;
        end else begin
            w = exp_q.pop_front();
        end
        chk($sformatf("word_%0d", rxi), word_acc, w);
        if (use_tab && rxi < NV) chk($sformatf("tab_bits_%0d", rxi), word_acc, vec[rxi].bits);
        if (pat_mode && rxi == 37) chk("pat_r2c5", word_acc, 16'h0025);
    endtask

    // One clock: observe this cycle's outputs, cross the edge, then drive inputs.
    task automatic cyc();
        logic acc;
        acc = pix_valid && pix_ready;
        if (pix_ready) ready_hi++;
        if (Vsync) begin
            vs_cnt++;
            if (DEN) vs_bad++;
        end
        if (done) begin
            done_cnt++;
            if (busy) vs_bad++;
        end
        if (busy && MODE_O !== exp_mode) mode_bad++;
        if (DEN) begin
            if (!seen_den) begin
                seen_den  = 1'b1;
                first_den = cyc_n;
            end
            if (run_len > 0) begin
                // between rows: GAP_CYC idle cycles plus the LOAD cycle
                if (run_len == GAP_CYC + 1) runs_gap++;
                else begin
                    runs_other++;
                    other_len = run_len;
                end
                run_len = 0;
            end
            den_hi++;
            word_acc = {word_acc[14:0], DAI};
            nb++;
            if (nb == 16) begin
                nb = 0;
                check_word();
                rxi++;
            end
        end else if (busy && seen_den) begin
            run_len++;
        end
        if (acc) begin
            if (acc_n == 0) first_acc = cyc_n;
            acc_n++;
            exp_q.push_back(pix_data);
        end
        @(posedge DCK);
        #1;
        cyc_n++;
        if (acc) begin
            src_i++;
            pix_data = src_word(src_i);
        end
        if (stall_left > 0 && pix_ready && acc_n == stall_at) begin
            pix_valid = 1'b0;
            stall_left--;
        end else begin
            pix_valid = 1'b1;
        end
    endtask

    task automatic run_frame(input string tag, input logic md, input bit hook,
                             input int want_other, input int want_len);
        int n;
        clear_stats();
        src_i    = 0;
        pix_data = src_word(0);
        exp_mode = md;
        mode     = md;
        start    = 1'b1;
        chk({tag, "_busy_before"}, busy, 1'b0);
        cyc();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, 1'b1);
        n = 0;
        while (done_cnt == 0 && n < 6000) begin
            if (hook) begin
                if (n % 333 == 100) mode = ~mode;
                start = (n == 1500) || Vsync || done;
            end
            cyc();
            n++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, done_cnt, 1);
        chk({tag, "_start_in_done_ignored"}, busy, 1'b0);
        chk({tag, "_den_cycles"}, den_hi, WORDS * 16);
        chk({tag, "_words_rx"}, rxi, WORDS);
        chk({tag, "_bits_left"}, nb, 0);
        chk({tag, "_row_gaps"}, runs_gap, ROW_RUNS);
        chk({tag, "_other_gaps"}, runs_other, want_other);
        if (want_other != 0) chk({tag, "_stall_den_low"}, other_len, want_len);
        chk({tag, "_vsync_cycles"}, vs_cnt, 2);
        chk({tag, "_vsync_den_done_busy"}, vs_bad, 0);
        chk({tag, "_mode_o_stable"}, mode_bad, 0);
        chk({tag, "_mode_o_after"}, MODE_O, md);
        if (pat_mode) begin
            chk({tag, "_accepts"}, acc_n, 0);
            chk({tag, "_ready_never"}, ready_hi, 0);
        end else begin
            chk({tag, "_accepts"}, acc_n, WORDS);
            chk({tag, "_queue_empty"}, exp_q.size(), 0);
            chk({tag, "_first_bit_latency"}, first_den - first_acc, 1);
        end
    endtask

    initial begin
        int n;
        int hold;
        vec[0] = '{16'hA5C3, 16'b1010_0101_1100_0011};
        vec[1] = '{16'h0001, 16'b0000_0000_0000_0001};
        vec[2] = '{16'h8000, 16'b1000_0000_0000_0000};
        vec[3] = '{16'hFFFF, 16'b1111_1111_1111_1111};
        vec[4] = '{16'h0000, 16'b0000_0000_0000_0000};
        vec[5] = '{16'h1234, 16'b0001_0010_0011_0100};
        vec[6] = '{16'h5A3C, 16'b0101_1010_0011_1100};

        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        pix_valid = 1'b1;
        pix_data  = 16'h0000;
        exp_mode  = 1'b0;
`ifdef LEDDC_TX_PATTERN_EN
        pat_sel   = 1'b0;
`endif
        clear_stats();
        repeat (3) @(posedge DCK);
        #1;
        chk("reset_outputs", {pix_ready, DAI, DEN, Vsync, MODE_O, busy, done}, 7'b0);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("idle_no_start", {pix_ready, DEN, busy}, 3'b000);

        // Frame A: continuous data, table words first
        use_tab = 1'b1;
        run_frame("frameA", 1'b0, 1'b0, 0, 0);
        use_tab = 1'b0;

        // Frame B: mode=1, mode toggling, stray starts, one stall at a word boundary
        stall_at   = 20;
        stall_left = 8;
        run_frame("frameB", 1'b1, 1'b1, 1, 8);
        stall_at   = -1;

        // Reset abort during row 3
        clear_stats();
        src_i    = 0;
        pix_data = src_word(0);
        exp_mode = 1'b1;
        mode     = 1'b1;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (acc_n < 50 && n < 2000) begin
            cyc();
            n++;
        end
        chk("abort_reached_row3", (acc_n >= 50), 1'b1);
        repeat (5) cyc();
        rst_n = 1'b0;
        cyc();
        chk("abort_outputs", {pix_ready, DAI, DEN, Vsync, MODE_O, busy, done}, 7'b0);
        rst_n = 1'b1;
        hold  = den_hi;
        repeat (20) cyc();
        chk("abort_no_den", den_hi - hold, 0);
        chk("abort_no_vsync", vs_cnt, 0);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", busy, 1'b0);

        // Full frame after the abort
        run_frame("post_rst", 1'b0, 1'b0, 0, 0);

`ifdef LEDDC_TX_PATTERN_EN
        pat_sel  = 1'b1;
        pat_mode = 1'b1;
        run_frame("pattern", 1'b0, 1'b0, 0, 0);
        pat_sel  = 1'b0;
        pat_mode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
